// File: rtl/clock_seq_pkg.sv
// Shared types and widths for the clock_scale step sequencer.
package clock_seq_pkg;

    localparam int unsigned SEQ_FACTOR_W = 11;
    localparam int unsigned SEQ_BEATS_W  = 4;
    localparam int unsigned SEQ_IDX_W    = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        NEXT = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [SEQ_FACTOR_W-1:0] factor;
        logic [SEQ_BEATS_W-1:0]  beats;
    } seq_entry_t;

endpackage

// File: rtl/clock_scale_sequencer_beat_timer.sv
// Beat time base: counts 0..BEAT_DIV-1 while running, ticks on the last count.
module beat_timer #(
    parameter int unsigned BEAT_DIV = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_tick
);

    localparam int unsigned CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEAT_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Beat counter; clear has priority so a new step or gap starts on a fresh beat.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= (r_count == LAST_CNT) ? '0 : r_count + CNT_W'(1);
        end
    end

    assign o_tick = i_run && (r_count == LAST_CNT);

endmodule

// File: rtl/clock_scale_sequencer.sv
// Step sequencer driving an external clock_scale divider from an 8-entry
// (factor, beats) table. Define CLOCK_SEQ_GAP_EN to insert one silent beat
// between consecutive steps.
module clock_scale_sequencer
    import clock_seq_pkg::*;
#(
    parameter int unsigned BEAT_DIV = 1000,
    parameter int unsigned STEPS    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_stop,
    input  logic                    i_loop,
    input  logic [SEQ_IDX_W-1:0]    i_last_step,
    input  logic                    i_wr_en,
    input  logic [SEQ_IDX_W-1:0]    i_wr_addr,
    input  logic [SEQ_FACTOR_W-1:0] i_wr_factor,
    input  logic [SEQ_BEATS_W-1:0]  i_wr_beats,
    output logic                    o_scaler_en,
    output logic                    o_scaler_rst,
    output logic [SEQ_FACTOR_W-1:0] o_scale_factor,
    output logic [SEQ_IDX_W-1:0]    o_step,
    output logic                    o_busy,
    output logic                    o_done
);

    seq_state_t              r_state;
    seq_state_t              w_next_state;
    seq_entry_t              r_table [STEPS];
    logic [SEQ_IDX_W-1:0]    r_step;
    logic [SEQ_IDX_W-1:0]    w_next_step;
    logic [SEQ_IDX_W-1:0]    r_last;
    logic [SEQ_BEATS_W-1:0]  r_beats;
    logic [SEQ_FACTOR_W-1:0] r_factor;
    logic                    r_fin;
    logic                    r_scaler_en;
    logic                    r_scaler_rst;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_start_acc;
    logic                    w_fin;
    logic                    w_timer_clr;
    logic                    w_timer_run;
    logic                    w_tick;

    assign w_timer_run = (r_state == PLAY) || (r_state == GAP);

    beat_timer #(.BEAT_DIV(BEAT_DIV)) u_beat_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_timer_clr),
        .i_run  (w_timer_run),
        .o_tick (w_tick)
    );

    // Table is plain storage: no reset, writes locked out during playback.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !r_busy) begin
            r_table[i_wr_addr] <= '{factor: i_wr_factor, beats: i_wr_beats};
        end
    end

    // Next-state, next-step and beat-timer control; stop overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        w_start_acc  = 1'b0;
        w_timer_clr  = 1'b0;
        // Sequence ends after this step when it is the last one and loop is low.
        w_fin        = (r_step == r_last) && !i_loop;
        if (i_stop) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_next_state = LOAD;
                        w_next_step  = '0;
                        w_start_acc  = 1'b1;
                    end
                end
                LOAD: begin
                    w_timer_clr  = 1'b1;
                    w_next_state = (r_beats == '0) ? NEXT : PLAY;
                end
                PLAY: begin
                    if (w_tick && (r_beats == SEQ_BEATS_W'(1))) begin
`ifdef CLOCK_SEQ_GAP_EN
                        w_next_state = GAP;
                        w_timer_clr  = 1'b1;
`else
                        w_next_state = NEXT;
`endif
                    end
                end
`ifdef CLOCK_SEQ_GAP_EN
                GAP: begin
                    if (w_tick) begin
                        w_next_state = NEXT;
                    end
                end
`endif
                NEXT: begin
                    if (r_fin) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = LOAD;
                        w_next_step  = (r_step == r_last) ? '0 : r_step + SEQ_IDX_W'(1);
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_step       <= '0;
            r_last       <= '0;
            r_beats      <= '0;
            r_factor     <= '0;
            r_fin        <= 1'b0;
            r_scaler_en  <= 1'b0;
            r_scaler_rst <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
            if (w_start_acc) begin
                r_last <= i_last_step;
            end
            if (w_next_state == LOAD) begin
                r_factor <= r_table[w_next_step].factor;
                r_beats  <= r_table[w_next_step].beats;
            end else if ((r_state == PLAY) && w_tick) begin
                r_beats <= r_beats - SEQ_BEATS_W'(1);
            end
            if ((w_next_state == NEXT) && (r_state != NEXT)) begin
                r_fin <= w_fin;
            end
            r_scaler_en  <= (w_next_state == LOAD) || (w_next_state == PLAY);
            r_scaler_rst <= (w_next_state == LOAD);
            r_busy       <= (w_next_state != IDLE);
            r_done       <= (w_next_state == NEXT) && (r_state != NEXT) && w_fin;
        end
    end

    assign o_scaler_en    = r_scaler_en;
    assign o_scaler_rst   = r_scaler_rst;
    assign o_scale_factor = r_factor;
    assign o_step         = r_step;
    assign o_busy         = r_busy;
    assign o_done         = r_done;

endmodule

// File: tb/tb_clock_scale_sequencer.sv
// Directed self-checking bench for clock_scale_sequencer with BEAT_DIV=4.
// Build with CLOCK_SEQ_GAP_EN defined to exercise the inter-step gap.
module tb_clock_scale_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_i = 1'b0;
    logic [2:0]  last_step = 3'd0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [10:0] wr_factor = 11'd0;
    logic [3:0]  wr_beats = 4'd0;
    logic        scaler_en;
    logic        scaler_rst;
    logic [10:0] scale_factor;
    logic [2:0]  step;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    clock_scale_sequencer #(.BEAT_DIV(4), .STEPS(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_stop         (stop),
        .i_loop         (loop_i),
        .i_last_step    (last_step),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_factor    (wr_factor),
        .i_wr_beats     (wr_beats),
        .o_scaler_en    (scaler_en),
        .o_scaler_rst   (scaler_rst),
        .o_scale_factor (scale_factor),
        .o_step         (step),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [10:0] f, input logic [3:0] b);
        wr_en = 1'b1; wr_addr = a; wr_factor = f; wr_beats = b;
        cyc();
        wr_en = 1'b0;
    endtask

    // Leaves the bench in cycle 1 (LOAD of step 0).
    task automatic start_seq(input logic [2:0] last, input logic lp);
        start = 1'b1; last_step = last; loop_i = lp;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            cyc();
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy still %b after timeout, required 0", name, busy);
        end
    endtask

    function automatic logic [17:0] obs();
        return {busy, scaler_en, scaler_rst, done, step, scale_factor};
    endfunction

    // Expected {busy,en,rst,done,step,factor} for the skip scenario.
    function automatic logic [17:0] exp_skip(input int c);
        case (c)
            1:                return {1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 11'd5};
            2, 3, 4, 5:       return {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 11'd5};
            6:                return {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 11'd5};
            7:                return {1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 11'd7};
            8:                return {1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 11'd7};
            9:                return {1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 11'd2};
            10, 11, 12, 13:   return {1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 11'd2};
            14:               return {1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 11'd2};
            default:          return {1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 11'd2};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        n_checks++;
        if (obs() !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required %h", obs(), 18'd0);
        end
        rst = 1'b0;
        cyc();
        n_checks++;
        if (obs() !== 18'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h, required %h", obs(), 18'd0);
        end
    endtask

    task automatic test_single();
        int en_bad;
        write_entry(3'd0, 11'd3, 4'd2);
        start_seq(3'd0, 1'b0);
        n_checks++;
        if ({scaler_en, scaler_rst, scale_factor, busy} !== {1'b1, 1'b1, 11'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL single_load: en/rst/factor/busy got %b/%b/%0d/%b, required 1/1/3/1",
                     scaler_en, scaler_rst, scale_factor, busy);
        end
        en_bad = 0;
        for (int c = 2; c <= 9; c++) begin
            cyc();
            if (scaler_en !== 1'b1 || scaler_rst !== 1'b0 || done !== 1'b0) en_bad++;
        end
        n_checks++;
        if (en_bad != 0) begin
            n_fail++;
            $display("FAIL single_play: %0d bad PLAY cycles, required 0", en_bad);
        end
        cyc();
        n_checks++;
        if ({done, scaler_en, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL single_done: done/en/busy got %b%b%b, required 101", done, scaler_en, busy);
        end
        cyc();
        n_checks++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_idle: done/busy got %b%b, required 00", done, busy);
        end
    endtask

    task automatic test_skip();
        write_entry(3'd0, 11'd5, 4'd1);
        write_entry(3'd1, 11'd7, 4'd0);
        write_entry(3'd2, 11'd2, 4'd1);
        start_seq(3'd2, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            n_checks++;
            if (obs() !== exp_skip(c)) begin
                n_fail++;
                $display("FAIL skip_cycle%0d: got %h, required %h", c, obs(), exp_skip(c));
            end
            if (c < 15) cyc();
        end
    endtask

    task automatic test_loop();
        int early_done;
        write_entry(3'd1, 11'd6, 4'd1);
        start_seq(3'd1, 1'b1);
        early_done = 0;
        for (int c = 1; c <= 25; c++) begin
            if (c <= 23 && done === 1'b1) early_done++;
            if (c == 7 || c == 19) begin
                n_checks++;
                if ({step, scaler_rst, scale_factor} !== {3'd1, 1'b1, 11'd6}) begin
                    n_fail++;
                    $display("FAIL loop_step1_c%0d: step/rst/factor got %0d/%b/%0d, required 1/1/6",
                             c, step, scaler_rst, scale_factor);
                end
            end
            if (c == 13) begin
                n_checks++;
                if ({step, scaler_rst, scale_factor} !== {3'd0, 1'b1, 11'd5}) begin
                    n_fail++;
                    $display("FAIL loop_wrap: step/rst/factor got %0d/%b/%0d, required 0/1/5",
                             step, scaler_rst, scale_factor);
                end
            end
            if (c == 24) begin
                n_checks++;
                if ({done, step} !== {1'b1, 3'd1}) begin
                    n_fail++;
                    $display("FAIL loop_done: done/step got %b/%0d, required 1/1", done, step);
                end
            end
            if (c == 25) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL loop_idle: busy got %b, required 0", busy);
                end
            end
            if (c == 21) loop_i = 1'b0;
            if (c < 25) cyc();
        end
        n_checks++;
        if (early_done != 0) begin
            n_fail++;
            $display("FAIL loop_early_done: %0d early done cycles, required 0", early_done);
        end
    endtask

    task automatic test_stop();
        // t0=(5,1), t1=(6,1) at this point
        start_seq(3'd1, 1'b1);
        cyc(); cyc();
        stop = 1'b1; start = 1'b1;
        cyc();
        stop = 1'b0; start = 1'b0;
        n_checks++;
        if ({busy, scaler_en, scaler_rst, step, scale_factor} !== {1'b0, 1'b0, 1'b0, 3'd0, 11'd5}) begin
            n_fail++;
            $display("FAIL stop_mid_play: busy/en/rst/step/factor got %b/%b/%b/%0d/%0d, required 0/0/0/0/5",
                     busy, scaler_en, scaler_rst, step, scale_factor);
        end
        cyc(); cyc(); cyc();
        n_checks++;
        if ({busy, scaler_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_no_restart: busy/en got %b%b, required 00", busy, scaler_en);
        end
        stop = 1'b1; start = 1'b1;
        cyc();
        stop = 1'b0; start = 1'b0;
        cyc();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_beats_start: busy got %b, required 0", busy);
        end
        loop_i = 1'b0;
        start_seq(3'd1, 1'b0);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++;
        if (obs() !== 18'd0) begin
            n_fail++;
            $display("FAIL rst_mid_play: got %h, required %h", obs(), 18'd0);
        end
        start_seq(3'd0, 1'b0);
        n_checks++;
        if (scale_factor !== 11'd5) begin
            n_fail++;
            $display("FAIL table_kept_after_rst: factor got %0d, required 5", scale_factor);
        end
        wait_idle("stop_wait_idle");
    endtask

    task automatic test_write_busy();
        start_seq(3'd0, 1'b0);
        cyc();
        wr_en = 1'b1; wr_addr = 3'd0; wr_factor = 11'd9; wr_beats = 4'd3;
        start = 1'b1;
        cyc();
        wr_en = 1'b0; start = 1'b0;
        n_checks++;
        if ({scaler_en, scaler_rst, step} !== {1'b1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL busy_start_ignored: en/rst/step got %b/%b/%0d, required 1/0/0",
                     scaler_en, scaler_rst, step);
        end
        cyc(); cyc(); cyc();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_run_done: done got %b, required 1", done);
        end
        cyc();
        start_seq(3'd0, 1'b0);
        n_checks++;
        if (scale_factor !== 11'd5) begin
            n_fail++;
            $display("FAIL busy_write_factor: got %0d, required 5", scale_factor);
        end
        cyc(); cyc(); cyc(); cyc(); cyc();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_write_beats: done got %b, required 1 (old 1-beat step)", done);
        end
        wait_idle("busy_wait_idle");
    endtask

`ifdef CLOCK_SEQ_GAP_EN
    task automatic test_gap();
        int silent;
        write_entry(3'd0, 11'd5, 4'd1);
        write_entry(3'd1, 11'd6, 4'd1);
        start_seq(3'd1, 1'b0);
        silent = 0;
        for (int c = 1; c <= 21; c++) begin
            if (c >= 2 && c <= 10 && scaler_en === 1'b0) silent++;
            if (c == 11) begin
                n_checks++;
                if ({scaler_en, scaler_rst, step, scale_factor} !== {1'b1, 1'b1, 3'd1, 11'd6}) begin
                    n_fail++;
                    $display("FAIL gap_load1: en/rst/step/factor got %b/%b/%0d/%0d, required 1/1/1/6",
                             scaler_en, scaler_rst, step, scale_factor);
                end
            end
            if (c == 20) begin
                n_checks++;
                if (done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_done: done got %b, required 1", done);
                end
            end
            if (c == 21) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_idle: busy got %b, required 0", busy);
                end
            end
            if (c < 21) cyc();
        end
        n_checks++;
        if (silent != 5) begin
            n_fail++;
            $display("FAIL gap_silence: %0d silent cycles, required 5", silent);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CLOCK_SEQ_GAP_EN
        test_gap();
        test_stop();
`else
        test_single();
        test_skip();
        test_loop();
        test_stop();
        test_write_busy();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
